// File: rtl/spi_ram_model.sv
// Serial SPI SRAM simulation model. The SPI pins are oversampled on the system
// clock. The model supports READ, FAST READ, WRITE and the mode-register
// commands, the byte/page/sequential address modes, and a registered debug view
// of memory as 32-bit words.
module spi_ram_model #(
   parameter int    DEPTH        = 4096,
   parameter int    ADDR_BITS    = 24,
   parameter int    PAGE_BYTES   = 32,
   parameter int    DUMMY_CYCLES = 8,
   parameter string INIT_FILE    = ""
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     spi_clk,
   input  logic                     spi_mosi,
   input  logic                     spi_select,
   output logic                     spi_miso,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [31:0]              dbg_data
);

   localparam int IDX_W      = $clog2(DEPTH);
   localparam int ADDR_TOTAL = ((ADDR_BITS + 7) / 8) * 8;
   localparam int CNT_MAX    = (ADDR_TOTAL > DUMMY_CYCLES) ? ADDR_TOTAL : DUMMY_CYCLES;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);
   localparam logic [ADDR_TOTAL-1:0] ADDR_MASK = ADDR_TOTAL'((65'd1 << ADDR_BITS) - 65'd1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_READ, ST_WRITE, ST_MODE_RD, ST_MODE_WR, ST_IGNORE
   } state_t;

   typedef enum logic [1:0] {
      K_READ, K_FAST, K_WRITE
   } cmd_kind_t;

   state_t                state;
   state_t                state_next;
   cmd_kind_t             cmd_kind;

   logic                  sclk_s1, sclk_s2, sclk_s3;
   logic                  mosi_s1, mosi_s2;
   logic                  sel_s1, sel_s2;
   logic                  sclk_rise, sclk_fall;

   logic [CNT_W-1:0]      bit_cnt;
   logic [6:0]            shift_reg;
   logic [7:0]            rx_byte;
   logic [ADDR_TOTAL-2:0] addr_shift;
   logic [ADDR_TOTAL-1:0] addr_full;
   logic [IDX_W-1:0]      addr_index;
   logic [IDX_W-1:0]      index;
   logic [7:0]            tx_byte;
   logic                  miso_reg;
   logic [7:0]            mode_reg;
   logic                  mode_done;
   logic                  addr_last, dummy_last, byte_last;

   logic                  wr_pending;
   logic [IDX_W-1:0]      wr_index;
   logic [7:0]            wr_data;

   logic [7:0]            mem [DEPTH];

   // Address step after each transferred byte, selected by mode[7:6].
   function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                    input logic [1:0] mode_bits);
      logic [IDX_W-1:0] inc;
      logic [IDX_W-1:0] page_mask;
      inc       = idx + IDX_W'(1);
      page_mask = IDX_W'(PAGE_BYTES - 1);
      case (mode_bits)
         2'b00:   next_index = idx;
         2'b10:   next_index = (idx & ~page_mask) | (inc & page_mask);
         default: next_index = inc;
      endcase
   endfunction

   assign sclk_rise  = sclk_s2 & ~sclk_s3;
   assign sclk_fall  = ~sclk_s2 & sclk_s3;
   assign rx_byte    = {shift_reg, mosi_s2};
   assign addr_full  = {addr_shift, mosi_s2};
   assign addr_index = IDX_W'(addr_full & ADDR_MASK);
   assign addr_last  = (bit_cnt == CNT_W'(ADDR_TOTAL - 1));
   assign dummy_last = (bit_cnt == CNT_W'(DUMMY_CYCLES - 1));
   assign byte_last  = (bit_cnt == CNT_W'(7));
   assign spi_miso   = miso_reg;

   // Two-flop synchronisers on the SPI pins plus one extra clock stage for edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
         sel_s1  <= 1'b1;
         sel_s2  <= 1'b1;
      end else begin
         sclk_s1 <= spi_clk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         mosi_s1 <= spi_mosi;
         mosi_s2 <= mosi_s1;
         sel_s1  <= spi_select;
         sel_s2  <= sel_s1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state decode: deselect wins, otherwise advance on completed command/address/dummy phases.
   always_comb begin
      state_next = state;
      if (sel_s2) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_next = ST_CMD;
            ST_CMD: begin
               if (sclk_rise && byte_last) begin
                  case (rx_byte)
                     8'h03, 8'h0B, 8'h02: state_next = ST_ADDR;
                     8'h05:               state_next = ST_MODE_RD;
                     8'h01:               state_next = ST_MODE_WR;
                     default:             state_next = ST_IGNORE;
                  endcase
               end
            end
            ST_ADDR: begin
               if (sclk_rise && addr_last) begin
                  if (cmd_kind == K_WRITE)                         state_next = ST_WRITE;
                  else if (cmd_kind == K_FAST && DUMMY_CYCLES > 0) state_next = ST_DUMMY;
                  else                                             state_next = ST_READ;
               end
            end
            ST_DUMMY: begin
               if (sclk_rise && dummy_last) state_next = ST_READ;
            end
            default: state_next = state;
         endcase
      end
   end

   // Serial datapath: shift in on rises, shift out on falls, step the address per byte.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cmd_kind   <= K_READ;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         addr_shift <= '0;
         index      <= '0;
         tx_byte    <= '0;
         miso_reg   <= 1'b0;
         mode_reg   <= 8'h40;
         mode_done  <= 1'b0;
         wr_pending <= 1'b0;
         wr_index   <= '0;
         wr_data    <= '0;
      end else begin
         wr_pending <= 1'b0;
         if (sel_s2) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            addr_shift <= '0;
            miso_reg   <= 1'b0;
            mode_done  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: bit_cnt <= '0;
               ST_CMD: begin
                  if (sclk_rise) begin
                     shift_reg <= rx_byte[6:0];
                     if (byte_last) begin
                        bit_cnt <= '0;
                        if (rx_byte == 8'h0B)      cmd_kind <= K_FAST;
                        else if (rx_byte == 8'h02) cmd_kind <= K_WRITE;
                        else                       cmd_kind <= K_READ;
                        if (state_next == ST_MODE_RD) tx_byte <= mode_reg;
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_ADDR: begin
                  if (sclk_rise) begin
                     addr_shift <= addr_full[ADDR_TOTAL-2:0];
                     if (addr_last) begin
                        bit_cnt <= '0;
                        index   <= addr_index;
                        if (state_next == ST_READ) tx_byte <= mem[addr_index];
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_DUMMY: begin
                  if (sclk_rise) begin
                     if (dummy_last) begin
                        bit_cnt <= '0;
                        tx_byte <= mem[index];
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_READ: begin
                  if (sclk_fall) begin
                     miso_reg <= tx_byte[7];
                     if (byte_last) begin
                        bit_cnt <= '0;
                        index   <= next_index(index, mode_reg[7:6]);
                        tx_byte <= mem[next_index(index, mode_reg[7:6])];
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        tx_byte <= {tx_byte[6:0], 1'b0};
                     end
                  end
               end
               ST_MODE_RD: begin
                  if (sclk_fall) begin
                     miso_reg <= tx_byte[7];
                     tx_byte  <= {tx_byte[6:0], tx_byte[7]};
                  end
               end
               ST_WRITE: begin
                  if (sclk_rise) begin
                     shift_reg <= rx_byte[6:0];
                     if (byte_last) begin
                        bit_cnt    <= '0;
                        wr_pending <= 1'b1;
                        wr_data    <= rx_byte;
                        wr_index   <= index;
                        index      <= next_index(index, mode_reg[7:6]);
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_MODE_WR: begin
                  if (sclk_rise) begin
                     shift_reg <= rx_byte[6:0];
                     if (byte_last) begin
                        bit_cnt <= '0;
                        if (!mode_done) begin
                           mode_reg  <= rx_byte;
                           mode_done <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end
               end
               default: miso_reg <= 1'b0;
            endcase
         end
      end
   end

   // Memory write port: a completed byte lands one clock after its last rise.
   always_ff @(posedge clk) begin
      if (wr_pending) mem[wr_index] <= wr_data;
   end

   // Registered debug word view; a same-cycle write shows up one clock later.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dbg_data <= '0;
      end else begin
         dbg_data <= {mem[dbg_addr + IDX_W'(3)], mem[dbg_addr + IDX_W'(2)],
                      mem[dbg_addr + IDX_W'(1)], mem[dbg_addr]};
      end
   end

endmodule

// File: tb/tb_spi_ram_model.sv
// Scoreboard bench for spi_ram_model: the driver queues expected MISO bytes and
// debug/pin values, and two monitors pop and compare as the DUT produces them.
module tb_spi_ram_model;

   localparam int HALF = 8;

   typedef struct {
      string       name;
      logic [31:0] val;
      bit          kind;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        spi_clk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_select = 1'b1;
   logic        spi_miso;
   logic [11:0] dbg_addr = '0;
   logic [31:0] dbg_data;

   bit          capture = 1'b0;
   bit          probe_req = 1'b0;
   exp_t        byte_q[$];
   exp_t        word_q[$];
   logic [7:0]  tx_q[$];
   int          checks = 0;
   int          errors = 0;

   spi_ram_model #(
      .DEPTH(4096), .ADDR_BITS(24), .PAGE_BYTES(32), .DUMMY_CYCLES(8), .INIT_FILE("")
   ) dut (
      .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_select(spi_select), .spi_miso(spi_miso), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic push_byte(input string name, input logic [7:0] val);
      exp_t e;
      e.name = name; e.val = {24'd0, val}; e.kind = 1'b0;
      byte_q.push_back(e);
   endtask

   task automatic probe(input string name, input bit kind, input logic [11:0] addr,
                        input logic [31:0] val);
      exp_t e;
      e.name = name; e.val = val; e.kind = kind;
      dbg_addr = addr;
      word_q.push_back(e);
      probe_req = ~probe_req;
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b);
      spi_mosi = b;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic spi_begin();
      spi_select = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_end();
      spi_mosi = 1'b0;
      spi_select = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Sends tx_q as one transaction; MISO bytes from index cap_from onwards are checked.
   task automatic applyStimulus(input int cap_from);
      spi_begin();
      for (int i = 0; i < tx_q.size(); i++) begin
         if (i == cap_from) capture = 1'b1;
         spi_byte(tx_q[i]);
      end
      capture = 1'b0;
      spi_end();
   endtask

   // MISO monitor: assembles bytes on SPI rises while capturing and scores them.
   initial begin : miso_monitor
      logic [7:0] sh;
      int         n;
      exp_t       e;
      sh = '0;
      n = 0;
      forever begin
         @(posedge spi_clk);
         if (capture) begin
            sh = {sh[6:0], spi_miso};
            n++;
            if (n == 8) begin
               n = 0;
               if (byte_q.size() == 0) begin
                  checks++; errors++;
                  $display("[TB] FAIL unexpected_byte: got 0x%02h expected none", sh);
               end else begin
                  e = byte_q.pop_front();
                  checkOutput(e.name, {24'd0, sh}, e.val);
               end
            end
         end else begin
            n = 0;
         end
      end
   end

   // Debug/pin monitor: samples dbg_data or spi_miso two clocks after each probe.
   initial begin : word_monitor
      exp_t e;
      forever begin
         @(probe_req);
         repeat (2) @(negedge clk);
         if (word_q.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_probe: got 0x%08h expected none", dbg_data);
         end else begin
            e = word_q.pop_front();
            checkOutput(e.name, e.kind ? {31'd0, spi_miso} : dbg_data, e.val);
         end
      end
   end

   initial begin : driver
      // Reset values
      repeat (2) @(negedge clk);
      probe("reset_dbg_data", 1'b0, 12'h000, 32'h0);
      probe("reset_miso", 1'b1, 12'h000, 32'h0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // Preload 0..3 and read them back
      tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(99);
      push_byte("read0_b0", 8'h11); push_byte("read0_b1", 8'h22);
      push_byte("read0_b2", 8'h33); push_byte("read0_b3", 8'h44);
      tx_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(4);
      probe("dbg_0", 1'b0, 12'h000, 32'h44332211);

      // Sequential write wrapping at the top of memory
      tx_q = '{8'h02, 8'h00, 8'h0F, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
      applyStimulus(99);
      probe("dbg_ffe_wrap", 1'b0, 12'hFFE, 32'h22CCBBAA);
      probe("dbg_0_after_wrap", 1'b0, 12'h000, 32'h443322CC);
      push_byte("read_fff", 8'hBB); push_byte("read_wrap_0", 8'hCC);
      tx_q = '{8'h03, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00};
      applyStimulus(4);

      // Page mode: write and read wrap inside a 32-byte page; mode register readback
      tx_q = '{8'h01, 8'h80};
      applyStimulus(99);
      push_byte("mode_rd_0", 8'h80); push_byte("mode_rd_repeat", 8'h80);
      tx_q = '{8'h05, 8'h00, 8'h00};
      applyStimulus(1);
      tx_q = '{8'h02, 8'h00, 8'h00, 8'h1E, 8'h77, 8'h88, 8'h99};
      applyStimulus(99);
      probe("dbg_page_wrap", 1'b0, 12'h000, 32'h44332299);
      push_byte("page_1e", 8'h77); push_byte("page_1f", 8'h88);
      push_byte("page_00", 8'h99); push_byte("page_01", 8'h22);
      tx_q = '{8'h03, 8'h00, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(4);

      // Byte mode: address does not advance; FAST READ with dummy clocks
      tx_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      applyStimulus(99);
      tx_q = '{8'h01, 8'h00};
      applyStimulus(99);
      tx_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h55, 8'h66};
      applyStimulus(99);
      probe("dbg_byte_mode", 1'b0, 12'h010, 32'hD4C3B266);
      push_byte("fast_b0", 8'h66); push_byte("fast_b1_same", 8'h66);
      tx_q = '{8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
      applyStimulus(5);

      // Partial byte at deselect is discarded
      tx_q = '{8'h01, 8'h40};
      applyStimulus(99);
      tx_q = '{8'h02, 8'h00, 8'h00, 8'h20, 8'h3C, 8'h3D, 8'h3E, 8'h3F};
      applyStimulus(99);
      spi_begin();
      spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h20);
      spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1);
      spi_end();
      probe("dbg_partial_discard", 1'b0, 12'h020, 32'h3F3E3D3C);
      push_byte("read_after_partial0", 8'h3C); push_byte("read_after_partial1", 8'h3D);
      tx_q = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
      applyStimulus(4);

      // Unknown command keeps MISO low
      for (int i = 0; i < 4; i++) push_byte("ignore_zero", 8'h00);
      tx_q = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(1);

      // Reset mid-READ while MISO is high
      tx_q = '{8'h01, 8'h80};
      applyStimulus(99);
      spi_begin();
      spi_byte(8'h03); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
      spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0); spi_bit(1'b0);
      repeat (4) @(negedge clk);
      probe("miso_high_before_reset", 1'b1, 12'h000, 32'h1);
      rstn = 1'b0;
      @(negedge clk);
      probe("miso_during_reset", 1'b1, 12'h000, 32'h0);
      spi_select = 1'b1;
      spi_clk = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      push_byte("mode_after_reset", 8'h40);
      tx_q = '{8'h05, 8'h00};
      applyStimulus(1);
      push_byte("read_after_reset", 8'h99);
      tx_q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      applyStimulus(4);

      repeat (10) @(negedge clk);
      checkOutput("byte_queue_drained", byte_q.size(), 32'd0);
      checkOutput("probe_queue_drained", word_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
